sample_recorder: RTL and testbench
==================================

SAMPLE_RECORDER -- requirements
Module: sample_recorder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of samples per capture; power of 2, >= 2.
REQ-003 SHALL have port I_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port I_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port I_start  input  1  arm request; sampled only in IDLE.
REQ-006 SHALL have port I_tick  input  1  one-cycle sample strobe, driven by the upstream period counter's carry output.
REQ-007 SHALL have port I_data  input  WIDTH  sample value; captured when I_tick=1 in CAPTURE.
REQ-008 SHALL have port I_rd_ready  input  1  downstream ready for readout.
REQ-009 SHALL have port O_rd_valid  output  1  readout data valid.
REQ-010 SHALL have port O_rd_data  output  WIDTH  readout sample.
REQ-011 SHALL have port O_rd_last  output  1  marks the final sample (index DEPTH-1) of a readout.
REQ-012 SHALL have port O_busy  output  1  high in CAPTURE and READOUT.
REQ-013 SHALL have port O_done  output  1  one-cycle pulse when the buffer becomes full.

Function
REQ-014 SHALL implement states IDLE, CAPTURE, READOUT.
REQ-015 IDLE: I_start=1 SHALL move to CAPTURE next cycle and clear the write pointer to 0; I_tick SHALL be ignored.
REQ-016 A cycle with I_start=1 and I_tick=1 in IDLE SHALL NOT capture; the first capture SHALL be the first I_tick seen in CAPTURE.
REQ-017 CAPTURE: each cycle with I_tick=1 SHALL store I_data at the write pointer and increment the pointer; cycles with I_tick=0 SHALL not change the buffer.
REQ-018 The write at pointer DEPTH-1 SHALL move to READOUT at the same edge and assert O_done for exactly the following cycle; the pointer SHALL NOT wrap to 0 in CAPTURE.
REQ-019 I_start SHALL be ignored in CAPTURE and READOUT.
REQ-020 READOUT: from the first cycle in READOUT, O_rd_valid=1 and O_rd_data=sample 0, in write order.
REQ-021 A transfer SHALL occur on each edge with O_rd_valid=1 and I_rd_ready=1; the read pointer SHALL then advance and O_rd_data SHALL show the next sample in the next cycle.
REQ-022 While O_rd_valid=1 and I_rd_ready=0, O_rd_data and O_rd_last SHALL hold stable.
REQ-023 O_rd_last SHALL be 1 exactly while the presented sample index is DEPTH-1.
REQ-024 The transfer with O_rd_last=1 SHALL return to IDLE; O_rd_valid SHALL be 0 the next cycle.
REQ-025 I_rd_ready held high SHALL give one sample per cycle with no bubbles.
REQ-026 O_rd_valid SHALL be 0 outside READOUT; O_busy=1 exactly in CAPTURE and READOUT.
REQ-027 I_tick during READOUT SHALL be ignored, so buffer contents never change during readout.

Reset
REQ-028 I_rst=1 at an edge SHALL force IDLE, zero both pointers, and set O_rd_valid=0, O_rd_last=0, O_busy=0, O_done=0, O_rd_data=0.
REQ-029 Reset SHALL override all other inputs, including mid-CAPTURE and mid-READOUT; the aborted capture SHALL never be read out.
REQ-030 Buffer storage SHALL NOT be reset.

Structure
REQ-031 The shared definitions file SHALL hold the state encodings and the WIDTH/DEPTH defaults; pointer width SHALL be derived from DEPTH.
REQ-032 Storage SHALL be one sub-module, sample_buffer: DEPTH x WIDTH register array with one synchronous write port and one read port.
REQ-033 sample_recorder SHALL contain only the FSM, pointers and output registers.

Verification
REQ-034 Reset, then I_start, then 16 ticks spaced 16 cycles apart with I_data=0x10+n -> O_done pulses once, one cycle after the 16th tick; readout with ready=1 gives 0x10..0x1F on 16 consecutive cycles, with O_rd_last only on 0x1F.
REQ-035 During readout, toggle I_rd_ready (1,0,0,1,...) -> no sample lost or duplicated; data held while ready=0.
REQ-036 I_start and I_tick both 1 in IDLE with I_data=0xAA -> 0xAA is not stored; the first sample read equals the first tick's data after arming.
REQ-037 I_rst pulsed after 7 captured ticks -> all outputs 0 next cycle; a fresh I_start plus 16 ticks reads out only the new data.
REQ-038 Ticks and I_start applied during READOUT -> ignored; readout data unchanged; after the last transfer, O_busy=0 and a new capture can arm.

Source files
------------

// File: rtl/sample_recorder_pkg.sv
// rtl/sample_recorder_pkg.sv - shared state encodings, size defaults and pointer sizing for the sample recorder
package sample_recorder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READOUT = 2'd2
    } state_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sample_buffer.sv
// rtl/sample_buffer.sv - DEPTH x WIDTH capture storage, one synchronous write port, one combinational read port
module sample_buffer
    import sample_recorder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Contents are deliberately left unreset; only the pointers define validity.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_recorder.sv
// rtl/sample_recorder.sv - arm, capture DEPTH ticked samples, then stream them out with valid/ready
module sample_recorder
    import sample_recorder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_start,
    input  logic             I_tick,
    input  logic [WIDTH-1:0] I_data,
    input  logic             I_rd_ready,
    output logic             O_rd_valid,
    output logic [WIDTH-1:0] O_rd_data,
    output logic             O_rd_last,
    output logic             O_busy,
    output logic             O_done
);

    localparam int            PW   = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_addr;
    logic [WIDTH-1:0] buf_rd_data;
    logic             wr_en;
    logic             fill_done;
    logic             xfer;

    sample_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_buffer (
        .clk     (I_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (I_data),
        .rd_addr (rd_addr),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // rd_addr looks one sample ahead so the output register always holds the presented sample.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        fill_done  = 1'b0;
        xfer       = 1'b0;
        rd_addr    = rd_ptr;
        case (state)
            ST_IDLE: begin
                if (I_start) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (I_tick) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST) begin
                        fill_done  = 1'b1;
                        rd_addr    = '0;
                        state_next = ST_READOUT;
                    end
                end
            end
            ST_READOUT: begin
                if (I_rd_ready) begin
                    xfer    = 1'b1;
                    rd_addr = rd_ptr + PW'(1);
                    if (rd_ptr == LAST) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            O_rd_valid <= 1'b0;
            O_rd_data  <= '0;
            O_rd_last  <= 1'b0;
            O_done     <= 1'b0;
        end else begin
            O_done <= fill_done;

            if (state == ST_IDLE && I_start) begin
                wr_ptr <= '0;
            end else if (wr_en && !fill_done) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            if (fill_done) begin
                rd_ptr     <= '0;
                O_rd_valid <= 1'b1;
                O_rd_data  <= buf_rd_data;
                O_rd_last  <= 1'b0;
            end else if (xfer) begin
                if (rd_ptr == LAST) begin
                    rd_ptr     <= '0;
                    O_rd_valid <= 1'b0;
                    O_rd_data  <= '0;
                    O_rd_last  <= 1'b0;
                end else begin
                    rd_ptr     <= rd_ptr + PW'(1);
                    O_rd_data  <= buf_rd_data;
                    O_rd_last  <= (rd_addr == LAST);
                end
            end
        end
    end

    assign O_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sample_recorder.sv
// tb/tb_sample_recorder.sv - randomized directed-sequence bench for sample_recorder against a queue-based model
module tb_sample_recorder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             tick;
    logic [WIDTH-1:0] data;
    logic             rd_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;
    logic             busy;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] cap_q[$];
    logic [WIDTH-1:0] out_q[$];
    bit               armed      = 1'b0;
    bit               exp_done   = 1'b0;
    bit               just_reset = 1'b0;

    sample_recorder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .I_clk      (clk),
        .I_rst      (rst),
        .I_start    (start),
        .I_tick     (tick),
        .I_data     (data),
        .I_rd_ready (rd_ready),
        .O_rd_valid (rd_valid),
        .O_rd_data  (rd_data),
        .O_rd_last  (rd_last),
        .O_busy     (busy),
        .O_done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a buffer fills with ticked samples once armed; a full buffer becomes a readout queue.
    task automatic model_edge();
        if (rst) begin
            armed      = 1'b0;
            exp_done   = 1'b0;
            just_reset = 1'b1;
            cap_q.delete();
            out_q.delete();
        end else begin
            just_reset = 1'b0;
            exp_done   = 1'b0;
            if (out_q.size() != 0) begin
                if (rd_ready) void'(out_q.pop_front());
            end else if (armed) begin
                if (tick) begin
                    cap_q.push_back(data);
                    if (cap_q.size() == DEPTH) begin
                        out_q    = cap_q;
                        armed    = 1'b0;
                        exp_done = 1'b1;
                    end
                end
            end else if (start) begin
                armed = 1'b1;
                cap_q.delete();
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit t, input logic [WIDTH-1:0] d, input bit rdy);
        rst      = r;
        start    = s;
        tick     = t;
        data     = d;
        rd_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(out_q.size() != 0));
        chk("rd_last",  32'(rd_last),  32'(out_q.size() == 1));
        chk("busy",     32'(busy),     32'(armed || out_q.size() != 0));
        chk("done",     32'(done),     32'(exp_done));
        if (out_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(out_q[0]));
        else if (just_reset)   chk("rd_data_rst", 32'(rd_data), 32'd0);
    endtask

    // gap < 0 picks a random 0..3 idle cycles before each tick.
    task automatic capture(input int n, input int gap, input bit seq, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
            for (int k = 0; k < g; k++) cyc(1'b0, 1'b0, 1'b0, WIDTH'($urandom), bit'($urandom_range(0, 1)));
            cyc(1'b0, 1'b0, 1'b1, seq ? WIDTH'(int'(base) + i) : WIDTH'($urandom), 1'b0);
        end
    endtask

    // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: random ready with start/tick noise.
    task automatic readout(input int mode, output int cycles);
        int n;
        n = 0;
        while (out_q.size() != 0 && n < 200) begin
            bit rdy;
            bit noise;
            rdy   = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 4) == 0 || (n % 4) == 3)
                                                     : bit'($urandom_range(0, 1));
            noise = (mode == 2);
            cyc(1'b0, noise & bit'($urandom_range(0, 1)), noise & bit'($urandom_range(0, 1)),
                WIDTH'($urandom), rdy);
            n++;
        end
        chk("readout_bound", 32'(out_q.size()), 32'd0);
        cycles = n;
    endtask

    initial begin
        int cycles;
        rst = 1'b1; start = 1'b0; tick = 1'b0; data = '0; rd_ready = 1'b0;

        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'h33, 1'b1);

        // Slow ticks with incrementing data, streamed out with ready held high.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        capture(DEPTH, 15, 1'b1, 8'h10);
        chk("first_sample_10", 32'(rd_data), 32'h10);
        readout(0, cycles);
        chk("readout_cycles", 32'(cycles), 32'(DEPTH));

        // Random capture, readout with stalling ready.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        capture(DEPTH, -1, 1'b0, 8'h00);
        readout(1, cycles);

        // Start and tick together in IDLE must not store the 0xAA.
        cyc(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0);
        capture(DEPTH, -1, 1'b1, 8'h55);
        chk("no_aa_first", 32'(rd_data), 32'h55);
        readout(1, cycles);

        // Abort a capture with reset, then a clean capture of new data.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        capture(7, -1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        capture(DEPTH, -1, 1'b1, 8'h80);
        chk("fresh_first_80", 32'(rd_data), 32'h80);
        readout(0, cycles);

        // Ticks and starts during readout are ignored; re-arm afterwards.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        capture(DEPTH, -1, 1'b0, 8'h00);
        readout(2, cycles);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("rearm_busy", 32'(busy), 32'd1);
        capture(DEPTH, -1, 1'b0, 8'h00);
        readout(2, cycles);

        // Reset in the middle of a readout.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        capture(DEPTH, 0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
